// File: rtl/alu_stage_mc_pkg.sv
// -----------------------------------------------------------------------------
// alu_stage_mc_pkg
// Shared definitions for the multi-cycle ALU stage: function-code constants,
// FSM state encoding and the shift/rotate decode helper.
// -----------------------------------------------------------------------------
package alu_stage_mc_pkg;

   localparam logic [3:0] FN_ADD = 4'b0000;
   localparam logic [3:0] FN_SUB = 4'b0001;
   localparam logic [3:0] FN_AND = 4'b0010;
   localparam logic [3:0] FN_OR  = 4'b0011;
   localparam logic [3:0] FN_NOT = 4'b0100;
   localparam logic [3:0] FN_SRA = 4'b1000;
   localparam logic [3:0] FN_SRL = 4'b1001;
   localparam logic [3:0] FN_SLL = 4'b1010;
   localparam logic [3:0] FN_ROL = 4'b1100;
   localparam logic [3:0] FN_ROR = 4'b1101;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // True for the codes that execute iteratively, one bit position per cycle.
   function automatic logic is_shift(input logic [3:0] func);
      logic r;
      case (func)
         FN_SRA, FN_SRL, FN_SLL, FN_ROL, FN_ROR: r = 1'b1;
         default:                                r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_stage_mc_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Combinational ALU: ADD/SUB (with signed overflow), AND, OR, NOT A and a
// single-bit-position shift/rotate of A. Unknown codes give 0 with no overflow.
// Ports:
//   i_a, i_b   operands (i_b ignored by NOT and shift/rotate codes)
//   i_func     function code
//   o_res      result
//   o_ovf      signed overflow, ADD/SUB only
// -----------------------------------------------------------------------------
module alu_core
   import alu_stage_mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [3:0]       i_func,
   output logic [WIDTH-1:0] o_res,
   output logic             o_ovf
);

   logic [WIDTH-1:0] w_bp;
   logic [WIDTH-1:0] w_sum;

   // Function decode; SUB is done as A + (~B + 1) so one adder serves both.
   always_comb begin
      w_bp  = (i_func == FN_SUB) ? (~i_b + WIDTH'(1)) : i_b;
      w_sum = i_a + w_bp;
      o_res = '0;
      o_ovf = 1'b0;
      case (i_func)
         FN_ADD, FN_SUB: begin
            o_res = w_sum;
            o_ovf = (i_a[WIDTH-1] == w_bp[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
         end
         FN_AND:  o_res = i_a & i_b;
         FN_OR:   o_res = i_a | i_b;
         FN_NOT:  o_res = ~i_a;
         FN_SRA:  o_res = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
         FN_SRL:  o_res = {1'b0, i_a[WIDTH-1:1]};
         FN_SLL:  o_res = {i_a[WIDTH-2:0], 1'b0};
         FN_ROL:  o_res = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
         FN_ROR:  o_res = {i_a[0], i_a[WIDTH-1:1]};
         default: o_res = '0;
      endcase
   end

endmodule

// File: rtl/alu_stage_mc.sv
// -----------------------------------------------------------------------------
// alu_stage_mc
// Multi-cycle ALU stage with valid/ready handshakes on both sides.
// Single-cycle ops register their result one edge after accept; shifts and
// rotates iterate one bit per cycle through alu_core.
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   in_valid / in_ready  operation handshake
//   RF_A, RF_B, Immed    operands; ALU_Bin_SEL picks Immed (1) or RF_B (0)
//   ALU_func             function code
//   out_valid/out_ready  result handshake
//   ALU_out, Zero_out, Ovf_out  registered result and flags
//   Busy                 iterative operation in progress
// -----------------------------------------------------------------------------
module alu_stage_mc
   import alu_stage_mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] RF_A,
   input  logic [WIDTH-1:0] RF_B,
   input  logic [WIDTH-1:0] Immed,
   input  logic             ALU_Bin_SEL,
   input  logic [3:0]       ALU_func,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_out,
   output logic             Zero_out,
   output logic             Ovf_out,
   output logic             Busy
);

   localparam int SHW = $clog2(WIDTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_out;
   logic [SHW-1:0]   r_cnt;
   logic [3:0]       r_op;
   logic             r_valid;
   logic             r_zero;
   logic             r_ovf;
   logic             r_busy;

   logic [WIDTH-1:0] w_b;
   logic [SHW-1:0]   w_amt;
   logic [WIDTH-1:0] w_core_a;
   logic [3:0]       w_core_func;
   logic [WIDTH-1:0] w_core_res;
   logic             w_core_ovf;
   logic             w_in_shift;
   logic             w_free;
   logic             w_accept;
   logic [WIDTH-1:0] w_idle_res;

   assign w_b        = ALU_Bin_SEL ? Immed : RF_B;
   assign w_amt      = w_b[SHW-1:0];
   assign w_in_shift = is_shift(ALU_func);

   // Result register can take a new value if empty or being drained now.
   assign w_free   = !r_valid || out_ready;
   assign in_ready = !Reset && (r_state == ST_IDLE) && w_free;
   assign w_accept = in_valid && in_ready;

   // The core sees live inputs in IDLE and the working register during SHIFT.
   assign w_core_a    = (r_state == ST_SHIFT) ? r_work : RF_A;
   assign w_core_func = (r_state == ST_SHIFT) ? r_op : ALU_func;

   // A shift by 0 passes A through unchanged.
   assign w_idle_res = w_in_shift ? RF_A : w_core_res;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .i_a    (w_core_a),
      .i_b    (w_b),
      .i_func (w_core_func),
      .o_res  (w_core_res),
      .o_ovf  (w_core_ovf)
   );

   // Control FSM, iterative shift datapath and registered outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_work  <= '0;
         r_out   <= '0;
         r_cnt   <= '0;
         r_op    <= 4'b0000;
         r_valid <= 1'b0;
         r_zero  <= 1'b1;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_in_shift && (w_amt != '0)) begin
                     r_work  <= RF_A;
                     r_op    <= ALU_func;
                     r_cnt   <= w_amt;
                     r_busy  <= 1'b1;
                     r_state <= ST_SHIFT;
                     // Accept implies the old result is gone (or was never there).
                     r_valid <= 1'b0;
                  end else begin
                     r_out   <= w_idle_res;
                     r_zero  <= (w_idle_res == '0);
                     r_ovf   <= w_in_shift ? 1'b0 : w_core_ovf;
                     r_valid <= 1'b1;
                  end
               end else if (out_ready) begin
                  r_valid <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (r_cnt == SHW'(1)) begin
                  // Final step: only commit once the result register is free,
                  // otherwise hold here with the counter parked at 1.
                  if (w_free) begin
                     r_out   <= w_core_res;
                     r_zero  <= (w_core_res == '0);
                     r_ovf   <= 1'b0;
                     r_valid <= 1'b1;
                     r_cnt   <= '0;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_work <= w_core_res;
                  r_cnt  <= r_cnt - SHW'(1);
                  if (out_ready) begin
                     r_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign ALU_out   = r_out;
   assign Zero_out  = r_zero;
   assign Ovf_out   = r_ovf;
   assign Busy      = r_busy;

endmodule

// File: tb/tb_alu_stage_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_stage_mc
// Scoreboard bench: the stimulus side pushes the reference result for every
// accepted operation, a negedge monitor pops and compares each consumed result.
// A second, 8-bit instance covers the narrow configuration.
// -----------------------------------------------------------------------------
module tb_alu_stage_mc;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] rf_a = 32'h0, rf_b = 32'h0, immed = 32'h0;
   logic        sel = 1'b0;
   logic [3:0]  func = 4'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] alu_out;
   logic        zero_out, ovf_out, busy;

   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [7:0]  a8 = 8'h0, b8 = 8'h0, imm8 = 8'h0;
   logic        sel8 = 1'b0;
   logic [3:0]  func8 = 4'h0;
   logic        out_valid8;
   logic [7:0]  alu_out8;
   logic        zero8, ovf8, busy8;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   // Free-running cycle counter used to measure accept spacing.
   always @(posedge clk) cyc <= cyc + 1;

   alu_stage_mc #(.WIDTH(32)) u_dut (
      .Clk(clk), .Reset(rst), .in_valid(in_valid), .in_ready(in_ready),
      .RF_A(rf_a), .RF_B(rf_b), .Immed(immed), .ALU_Bin_SEL(sel), .ALU_func(func),
      .out_valid(out_valid), .out_ready(out_ready), .ALU_out(alu_out),
      .Zero_out(zero_out), .Ovf_out(ovf_out), .Busy(busy)
   );

   alu_stage_mc #(.WIDTH(8)) u_dut8 (
      .Clk(clk), .Reset(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .RF_A(a8), .RF_B(b8), .Immed(imm8), .ALU_Bin_SEL(sel8), .ALU_func(func8),
      .out_valid(out_valid8), .out_ready(1'b1), .ALU_out(alu_out8),
      .Zero_out(zero8), .Ovf_out(ovf8), .Busy(busy8)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain arithmetic on the specified rules.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] rb,
                                  input logic [31:0] im, input logic s, input logic [3:0] fn);
      exp_t        e;
      logic [31:0] b;
      logic [31:0] bn;
      logic signed [31:0] sa;
      longint      sum;
      int          amt;
      b     = s ? im : rb;
      amt   = int'(b[4:0]);
      sa    = a;
      e.ovf = 1'b0;
      case (fn)
         4'h0: begin
            e.res = a + b;
            sum   = longint'($signed(a)) + longint'($signed(b));
            e.ovf = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
         end
         4'h1: begin
            bn    = 32'd0 - b;
            e.res = a + bn;
            sum   = longint'($signed(a)) + longint'($signed(bn));
            e.ovf = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
         end
         4'h2: e.res = a & b;
         4'h3: e.res = a | b;
         4'h4: e.res = ~a;
         4'h8: e.res = sa >>> amt;
         4'h9: e.res = a >> amt;
         4'hA: e.res = a << amt;
         4'hC: e.res = (amt == 0) ? a : ((a << amt) | (a >> (32 - amt)));
         4'hD: e.res = (amt == 0) ? a : ((a >> amt) | (a << (32 - amt)));
         default: e.res = 32'h0;
      endcase
      e.zero = (e.res == 32'h0);
      return e;
   endfunction

   // Monitor: every consumed result must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", {32'h0, alu_out}, 64'hDEAD);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_alu_out", {32'h0, alu_out}, {32'h0, e.res});
            chk("sb_zero", {63'h0, zero_out}, {63'h0, e.zero});
            chk("sb_ovf", {63'h0, ovf_out}, {63'h0, e.ovf});
         end
      end
   end

   // Offer one op and return one #1 after its accept edge.
   task automatic send(input logic [31:0] a, input logic [31:0] rb, input logic [31:0] im,
                       input logic s, input logic [3:0] fn, input bit rand_bp, output int acc_cyc);
      int g;
      g = 0;
      rf_a = a; rf_b = rb; immed = im; sel = s; func = fn;
      in_valid = 1'b1;
      forever begin
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (in_ready || g >= 300) break;
         @(posedge clk); #1;
         g++;
      end
      if (g >= 300) begin
         chk("accept_timeout", 64'(g), 64'd0);
      end else begin
         exp_q.push_back(model(a, rb, im, s, fn));
      end
      acc_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges from accept until out_valid; optionally require Busy meanwhile.
   task automatic expect_latency(input string name, input int exp_edges, input bit chk_busy);
      int e;
      e = 0;
      while (!out_valid && e < 64) begin
         if (chk_busy) begin
            chk({name, "_busy"}, {63'h0, busy}, 64'd1);
            chk({name, "_in_ready"}, {63'h0, in_ready}, 64'd0);
         end
         @(posedge clk); #1;
         e++;
      end
      chk({name, "_latency"}, 64'(e), 64'(exp_edges));
      if (chk_busy) chk({name, "_busy_done"}, {63'h0, busy}, 64'd0);
   endtask

   task automatic drain();
      int g;
      g = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1, c2, e8;
      logic [3:0] codes [12];
      codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hF, 4'h6};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'h0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
      chk("rst_alu_out", {32'h0, alu_out}, 64'd0);
      chk("rst_zero", {63'h0, zero_out}, 64'd1);
      chk("rst_ovf", {63'h0, ovf_out}, 64'd0);
      chk("rst_busy", {63'h0, busy}, 64'd0);
      #2 rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {63'h0, in_ready}, 64'd1);
      @(posedge clk); #1;

      // Back-to-back ADD overflow then SUB to zero
      send(32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 4'h0, 1'b0, c1);
      chk("add_valid", {63'h0, out_valid}, 64'd1);
      chk("add_out", {32'h0, alu_out}, 64'h8000_0000);
      chk("add_ovf", {63'h0, ovf_out}, 64'd1);
      send(32'h5, 32'h5, 32'h0, 1'b0, 4'h1, 1'b0, c2);
      chk("sub_valid", {63'h0, out_valid}, 64'd1);
      chk("sub_zero", {63'h0, zero_out}, 64'd1);
      chk("b2b_spacing", 64'(c2 - c1), 64'd1);

      // SRA by 4 via Immed
      send(32'h8000_0010, 32'h0, 32'h4, 1'b1, 4'h8, 1'b0, c1);
      expect_latency("sra4", 4, 1'b1);
      chk("sra4_out", {32'h0, alu_out}, 64'hF800_0001);

      // Rotate edge amounts and upper amount bits ignored
      send(32'h8000_0001, 32'h1, 32'h0, 1'b0, 4'hC, 1'b0, c1);
      expect_latency("rol1", 1, 1'b1);
      chk("rol1_out", {32'h0, alu_out}, 64'h3);
      send(32'h3, 32'h0, 32'h0, 1'b0, 4'hD, 1'b0, c1);
      expect_latency("ror0", 0, 1'b0);
      chk("ror0_out", {32'h0, alu_out}, 64'h3);
      send(32'h8000_0001, 32'h21, 32'h0, 1'b0, 4'hC, 1'b0, c1);
      expect_latency("rol_0x21", 1, 1'b1);
      chk("rol_0x21_out", {32'h0, alu_out}, 64'h3);
      drain();

      // Back-pressure: result pending, AND offered, then drain+accept
      out_ready = 1'b0;
      send(32'hF0F0_1234, 32'h0F0F_0001, 32'h0, 1'b0, 4'h3, 1'b0, c1);
      rf_a = 32'hFFFF_0000; rf_b = 32'h1234_5678; sel = 1'b0; func = 4'h2;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", {63'h0, in_ready}, 64'd0);
         chk("bp_valid", {63'h0, out_valid}, 64'd1);
         chk("bp_hold", {32'h0, alu_out}, 64'hFFFF_1235);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {63'h0, in_ready}, 64'd1);
      exp_q.push_back(model(32'hFFFF_0000, 32'h1234_5678, 32'h0, 1'b0, 4'h2));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_and_valid", {63'h0, out_valid}, 64'd1);
      chk("bp_and_out", {32'h0, alu_out}, 64'h1234_0000);
      drain();

      // Asynchronous reset in the middle of SLL by 20
      send(32'h1, 32'h0, 32'd20, 1'b1, 4'hA, 1'b0, c1);
      repeat (4) begin @(posedge clk); #1; end
      chk("mid_shift_busy", {63'h0, busy}, 64'd1);
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      chk("arst_busy", {63'h0, busy}, 64'd0);
      chk("arst_valid", {63'h0, out_valid}, 64'd0);
      chk("arst_out", {32'h0, alu_out}, 64'd0);
      chk("arst_zero", {63'h0, zero_out}, 64'd1);
      chk("arst_in_ready", {63'h0, in_ready}, 64'd0);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      send(32'h0, 32'h0, 32'h0, 1'b0, 4'h4, 1'b0, c1);
      chk("not0_out", {32'h0, alu_out}, 64'hFFFF_FFFF);
      drain();

      // Randomized operations with random back-pressure
      for (int n = 0; n < 200; n++) begin
         logic [31:0] ra, rb, ri;
         ra = $urandom();
         rb = $urandom();
         ri = $urandom();
         case ($urandom_range(0, 5))
            0: ra = 32'h7FFF_FFFF;
            1: ra = 32'h8000_0000;
            2: rb = 32'h8000_0000;
            3: rb = ra;
            default: ;
         endcase
         send(ra, rb, ri, 1'($urandom_range(0, 1)), codes[$urandom_range(0, 11)], 1'b1, c1);
      end
      drain();

      // Narrow instance: SRL 0x80 by 7, then undefined code
      @(posedge clk); #1;
      a8 = 8'h80; b8 = 8'h07; sel8 = 1'b0; func8 = 4'h9; in_valid8 = 1'b1;
      chk("w8_in_ready", {63'h0, in_ready8}, 64'd1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      e8 = 0;
      while (!out_valid8 && e8 < 40) begin @(posedge clk); #1; e8++; end
      chk("w8_srl_latency", 64'(e8), 64'd7);
      chk("w8_srl_out", {56'h0, alu_out8}, 64'h01);
      a8 = 8'hFF; b8 = 8'h3C; func8 = 4'hF; in_valid8 = 1'b1;
      #1;
      chk("w8_undef_ready", {63'h0, in_ready8}, 64'd1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      chk("w8_undef_valid", {63'h0, out_valid8}, 64'd1);
      chk("w8_undef_out", {56'h0, alu_out8}, 64'h0);
      chk("w8_undef_zero", {63'h0, zero8}, 64'd1);
      chk("w8_undef_ovf", {63'h0, ovf8}, 64'd0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
